// File: rtl/example1_pkg.sv
// example1_pkg: shared types, bit mapping and golden function for the example1 sweep controller
package example1_pkg;
    localparam int VEC_W = 6;
    localparam int A_IDX = 5;
    localparam int B_IDX = 4;
    localparam int C_IDX = 3;
    localparam int D_IDX = 2;
    localparam int E_IDX = 1;
    localparam int F_IDX = 0;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
    function automatic logic ex1_golden(input logic [VEC_W-1:0] v);
        logic a, b, c, d, e, f;
        a = v[A_IDX];
        b = v[B_IDX];
        c = v[C_IDX];
        d = v[D_IDX];
        e = v[E_IDX];
        f = v[F_IDX];
        return ~(~(a & b) & (c & ~b & d) & ~(e | f));
    endfunction
endpackage

// File: rtl/example1_golden.sv
// example1_golden: combinational expected y for one input vector
module example1_golden
    import example1_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             y
);
    assign y = ex1_golden(vec);
endmodule

// File: rtl/example1_sweep_ctrl.sv
// example1_sweep_ctrl: sweeps example1 inputs over a vector range, samples y after settling and checks it
module example1_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 3,
    parameter int VEC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] first_vec,
    input  logic [VEC_W-1:0] last_vec,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             busy,
    output logic             done,
    output logic [6:0]       ones_count,
    output logic [6:0]       err_count,
    output logic             err_flag,
    output logic [VEC_W-1:0] first_err_vec
);
    import example1_pkg::*;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);
    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] stop_vec;
    logic [3:0]       cnt;
    logic             exp_y;
    logic             miss;
    example1_golden u_golden (.vec(vec), .y(exp_y));
    assign miss = y_in != exp_y;
    assign a = vec[A_IDX];
    assign b = vec[B_IDX];
    assign c = vec[C_IDX];
    assign d = vec[D_IDX];
    assign e = vec[E_IDX];
    assign f = vec[F_IDX];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            vec           <= '0;
            stop_vec      <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ones_count    <= '0;
            err_count     <= '0;
            err_flag      <= 1'b0;
            first_err_vec <= '0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state         <= SETTLE;
                            vec           <= first_vec;
                            stop_vec      <= last_vec;
                            cnt           <= CNT_INIT;
                            busy          <= 1'b1;
                            ones_count    <= '0;
                            err_count     <= '0;
                            err_flag      <= 1'b0;
                            first_err_vec <= '0;
                        end
                    end
                    SETTLE: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        ones_count <= ones_count + 7'(y_in);
                        err_count  <= err_count + 7'(miss);
                        err_flag   <= err_flag | miss;
                        if (miss && err_count == '0) first_err_vec <= vec;
                        if (vec == stop_vec) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec   <= vec + 1'b1;
                            cnt   <= CNT_INIT;
                            state <= SETTLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_example1_sweep_ctrl.sv
// tb_example1_sweep_ctrl: directed and randomized sweeps checked against a vector-list reference model
module tb_example1_sweep_ctrl;
    localparam int S = 3;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic       abort = 0;
    logic [5:0] first_vec = 0;
    logic [5:0] last_vec = 0;
    logic       y_in;
    logic       a, b, c, d, e, f, busy, done, err_flag;
    logic [6:0] ones_count, err_count;
    logic [5:0] first_err_vec;
    logic [5:0] abcdef;
    logic       y_gate;
    int         mode = 0;
    logic [63:0] flip = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_ones, exp_err, exp_fev;
    int exp_seq[$];
    int seen[$];

    example1_sweep_ctrl #(.SETTLE_CYCLES(S), .VEC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_vec(first_vec), .last_vec(last_vec), .y_in(y_in),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .busy(busy), .done(done), .ones_count(ones_count), .err_count(err_count),
        .err_flag(err_flag), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;
    assign abcdef = {a, b, c, d, e, f};
    assign y_gate = ~(~(a & b) & (c & ~b & d) & ~(e | f));
    assign y_in = (mode == 1) ? 1'b1 : (y_gate ^ (mode == 2 && flip[abcdef]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int fv, input int lv);
        int v;
        int y;
        int good;
        v = fv;
        exp_ones = 0;
        exp_err = 0;
        exp_fev = 0;
        exp_seq.delete();
        forever begin
            exp_seq.push_back(v);
            good = (v == 12 || v == 44) ? 0 : 1;
            y = (mode == 1) ? 1 : good ^ ((mode == 2 && flip[v]) ? 1 : 0);
            exp_ones += y;
            if (y != good) begin
                if (exp_err == 0) exp_fev = v;
                exp_err++;
            end
            if (v == lv) break;
            v = (v + 1) % 64;
        end
    endtask

    task automatic sweep(input string tag, input int fv, input int lv, input int restart_at);
        int edges;
        int n;
        int bad;
        edges = 0;
        model(fv, lv);
        n = exp_seq.size();
        seen.delete();
        @(negedge clk);
        first_vec = 6'(fv);
        last_vec = 6'(lv);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        seen.push_back(int'(abcdef));
        chk({tag, " busy_on"}, busy, 1);
        while (edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == restart_at) begin
                start = 1;
                first_vec = ~first_vec;
                last_vec = last_vec + 6'd3;
            end else start = 0;
            if (busy && int'(abcdef) != seen[$]) seen.push_back(int'(abcdef));
            if (done) break;
        end
        start = 0;
        chk({tag, " done_edge"}, edges, n * (S + 1));
        chk({tag, " busy_off"}, busy, 0);
        chk({tag, " ones"}, ones_count, exp_ones);
        chk({tag, " errs"}, err_count, exp_err);
        chk({tag, " err_flag"}, err_flag, exp_err != 0);
        chk({tag, " first_err"}, first_err_vec, exp_fev);
        bad = (seen.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < seen.size(); i++) if (seen[i] != exp_seq[i]) bad++;
        chk({tag, " vec_seq"}, bad, 0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " ones_hold"}, ones_count, exp_ones);
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ones", ones_count, 0);
        chk("rst errs", err_count, 0);
        chk("rst flag", err_flag, 0);
        chk("rst fev", first_err_vec, 0);
        chk("rst abcdef", abcdef, 0);
        rst_n = 1;
        mode = 0;
        sweep("full", 0, 63, 0);
        chk("full ones62", ones_count, 62);
        mode = 1;
        sweep("stuck1", 0, 63, 0);
        mode = 1;
        sweep("wrap", 62, 1, 0);
        mode = 0;
        sweep("single", 44, 44, 0);
        chk("single abcdef", abcdef, 6'b101100);
        sweep("restart", 0, 63, 20);
        @(negedge clk);
        first_vec = 0;
        last_vec = 63;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (40) @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort ones", ones_count, 10);
        chk("abort errs", err_count, 0);
        chk("abort vec", abcdef, 10);
        dn = 0;
        repeat (8) begin
            @(posedge clk);
            #1 dn += int'(done) + int'(busy);
        end
        chk("abort quiet", dn, 0);
        @(negedge clk);
        abort = 1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        abort = 0;
        chk("abort_start busy", busy, 0);
        chk("abort_start ones", ones_count, 10);
        @(negedge clk);
        first_vec = 0;
        last_vec = 63;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (50) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst ones", ones_count, 0);
        chk("midrst errs", err_count, 0);
        chk("midrst fev", first_err_vec, 0);
        chk("midrst abcdef", abcdef, 0);
        rst_n = 1;
        sweep("after_rst", 0, 63, 0);
        for (int i = 0; i < 6; i++) begin
            int fv, lv;
            mode = 2;
            flip = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            fv = $urandom_range(0, 63);
            lv = $urandom_range(0, 63);
            sweep("rand", fv, lv, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
